// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl -- sequencing controller for the Fibonacci datapath.
//
// The datapath has two registered words A/B and an adder between them. On an
// accepted start this block loads the pair (A=0, B=1) for one cycle, then
// issues exactly n add steps (A<=B, B<=A+B), so A ends up holding F(n). If the
// adder's carry-out rises during a step, the run is aborted and flagged. The
// block holds no data bits. The datapath acts on init/add_en at the same clock
// edge that samples them.
//
// Ports
//   clk        in   system clock, rising edge
//   CLR        in   asynchronous active-high reset
//   start      in   run request, level-sensitive, sampled only in IDLE
//   n          in   Fibonacci index, captured with an accepted start
//   ovf_in     in   adder carry-out, meaningful while add_en=1
//   busy       out  high in INIT and RUN
//   init       out  datapath load A=0/B=1 (INIT state)
//   add_en     out  datapath step enable (RUN state)
//   iter       out  add steps completed in the current run
//   done       out  one-cycle completion pulse (DONE state)
//   result_ok  out  A holds a valid F(n); held until the next accepted start
//   overflow   out  sticky abort flag; cleared by the next accepted start
//   err        out  one-cycle pulse: start rejected because n > MAX_N
module fib_seq_ctrl #(
  parameter int NW    = 5,
  parameter int MAX_N = 24
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          start,
  input  logic [NW-1:0] n,
  input  logic          ovf_in,
  output logic          busy,
  output logic          init,
  output logic          add_en,
  output logic [NW-1:0] iter,
  output logic          done,
  output logic          result_ok,
  output logic          overflow,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  // MAX_N fits in NW bits. The extra bit keeps the compare unsigned.
  localparam logic [NW:0] MAX_W = MAX_N[NW:0];

  state_t        state, state_nx;
  logic [NW-1:0] n_reg, cnt;
  logic          in_range, accept, reject, last_step;

  assign in_range  = {1'b0, n} <= MAX_W;
  assign accept    = (state == S_IDLE) && start && in_range;
  assign reject    = (state == S_IDLE) && start && !in_range;
  // cnt < n_reg <= MAX_N < 2^NW, so this increment cannot wrap.
  assign last_step = (cnt + 1'b1) == n_reg;

  // State register
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_INIT;
      S_INIT: state_nx = (n_reg == '0) ? S_DONE : S_RUN;
      // A carry voids the step and ends the run at once.
      S_RUN:  if (ovf_in || last_step) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register. They drop as soon as CLR
  // clears the state.
  always_comb begin
    init   = 1'b0;
    add_en = 1'b0;
    done   = 1'b0;
    case (state)
      S_INIT: init   = 1'b1;
      S_RUN:  add_en = 1'b1;
      S_DONE: done   = 1'b1;
      default: ;
    endcase
  end

  assign busy = init | add_en;
  assign iter = cnt;

  // Run bookkeeping: captured index, step counter, and status flags
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      n_reg     <= '0;
      cnt       <= '0;
      result_ok <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        n_reg     <= n;
        result_ok <= 1'b0;
        overflow  <= 1'b0;
      end
      case (state)
        S_INIT: cnt <= '0;
        S_RUN: begin
          if (ovf_in) overflow <= 1'b1;
          else        cnt      <= cnt + 1'b1;
        end
        S_DONE: result_ok <= ~overflow;
        default: ;
      endcase
    end
  end

endmodule
